// File: rtl/pe_pkg.sv
// Shared constants, result type and the saturating adder for the pe_dbuf processing element.
package pe_pkg;

   localparam int PIPE_MIN = 1;
   localparam int PIPE_MAX = 3;
   localparam int MAX_BW   = 64;

   typedef struct packed {
      logic              ovf;
      logic [MAX_BW-1:0] sum;
   } sat_res_t;

   function automatic bit cfg_ok(input int mul_bw, input int add_bw, input int pipe);
      return (add_bw >= 2 * mul_bw) && (add_bw < MAX_BW) &&
             (pipe >= PIPE_MIN) && (pipe <= PIPE_MAX);
   endfunction

   // Operands arrive already extended to MAX_BW, so the 64-bit sum is exact;
   // overflow is judged against a bw-bit result and only the low bw bits matter.
   function automatic sat_res_t sat_add(input logic [MAX_BW-1:0] a,
                                        input logic [MAX_BW-1:0] b,
                                        input int                bw,
                                        input bit                sgn,
                                        input bit                sat);
      logic [MAX_BW-1:0] sum;
      logic [MAX_BW-1:0] hi_mask;
      logic [MAX_BW-1:0] sgn_mask;
      logic [MAX_BW-1:0] top_bits;
      logic [MAX_BW-1:0] umax;
      logic [MAX_BW-1:0] smax;
      sat_res_t          r;
      sum      = a + b;
      hi_mask  = {MAX_BW{1'b1}} << bw;
      sgn_mask = {MAX_BW{1'b1}} << (bw - 1);
      umax     = ~hi_mask;
      smax     = umax >> 1;
      top_bits = sum & sgn_mask;
      r.sum    = sum;
      r.ovf    = 1'b0;
      if (sgn) begin
         r.ovf = (top_bits != '0) && (top_bits != sgn_mask);
         if (r.ovf && sat) r.sum = sum[MAX_BW-1] ? ~smax : smax;
      end else begin
         r.ovf = |(sum & hi_mask);
         if (r.ovf && sat) r.sum = umax;
      end
      return r;
   endfunction

endpackage

// File: rtl/pe_dbuf_if.sv
// Handshake and data bundle for one systolic cell: activation/psum, weight chain and outputs.
interface pe_dbuf_if #(
   parameter int MUL_BW = 16,
   parameter int ADD_BW = 32
);
   logic              i_valid;
   logic [MUL_BW-1:0] i_left;
   logic [ADD_BW-1:0] i_top;
   logic              i_swap;
   logic              i_wload;
   logic [MUL_BW-1:0] i_wtop;
   logic              i_clr_ovf;
   logic [MUL_BW-1:0] o_right;
   logic              o_right_valid;
   logic              o_swap;
   logic [ADD_BW-1:0] o_bot;
   logic              o_bot_valid;
   logic [MUL_BW-1:0] o_wbot;
   logic              o_wload;
   logic              o_ovf;

   modport master (
      output i_valid, i_left, i_top, i_swap, i_wload, i_wtop, i_clr_ovf,
      input  o_right, o_right_valid, o_swap, o_bot, o_bot_valid, o_wbot, o_wload, o_ovf
   );

   modport slave (
      input  i_valid, i_left, i_top, i_swap, i_wload, i_wtop, i_clr_ovf,
      output o_right, o_right_valid, o_swap, o_bot, o_bot_valid, o_wbot, o_wload, o_ovf
   );
endinterface

// File: rtl/pe_mac_pipe.sv
// Multiply / extend / add / saturate datapath with 1..3 register stages and a matching valid chain.
module pe_mac_pipe
   import pe_pkg::*;
#(
   parameter int MUL_BW = 16,
   parameter int ADD_BW = 32,
   parameter int PIPE   = 1,
   parameter int SIGNED = 1,
   parameter int SAT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic [MUL_BW-1:0] act,
   input  logic [MUL_BW-1:0] wgt,
   input  logic [ADD_BW-1:0] psum,
   output logic [ADD_BW-1:0] bot,
   output logic              bot_valid,
   output logic              ovf_set
);

   logic [2*MUL_BW-1:0] act_x, wgt_x, prod_c;
   logic [2*MUL_BW-1:0] prod_a;
   logic [ADD_BW-1:0]   psum_a;
   logic                v_a;
   logic [MAX_BW-1:0]   prod_x, psum_x;
   sat_res_t            res_c;
   logic [ADD_BW-1:0]   sum_b;
   logic                ovf_b, v_b;
   logic                unused_res_hi;

   always_comb begin
      if (SIGNED != 0) begin
         act_x = {{MUL_BW{act[MUL_BW-1]}}, act};
         wgt_x = {{MUL_BW{wgt[MUL_BW-1]}}, wgt};
      end else begin
         act_x = {{MUL_BW{1'b0}}, act};
         wgt_x = {{MUL_BW{1'b0}}, wgt};
      end
      prod_c = act_x * wgt_x;
   end

   if (PIPE >= 2) begin : g_mul_reg
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            prod_a <= '0;
            psum_a <= '0;
            v_a    <= 1'b0;
         end else begin
            v_a <= valid;
            if (valid) begin
               prod_a <= prod_c;
               psum_a <= psum;
            end
         end
      end
   end else begin : g_mul_comb
      assign prod_a = prod_c;
      assign psum_a = psum;
      assign v_a    = valid;
   end

   always_comb begin
      if (SIGNED != 0) begin
         prod_x = {{(MAX_BW-2*MUL_BW){prod_a[2*MUL_BW-1]}}, prod_a};
         psum_x = {{(MAX_BW-ADD_BW){psum_a[ADD_BW-1]}}, psum_a};
      end else begin
         prod_x = {{(MAX_BW-2*MUL_BW){1'b0}}, prod_a};
         psum_x = {{(MAX_BW-ADD_BW){1'b0}}, psum_a};
      end
      res_c = sat_add(prod_x, psum_x, ADD_BW, SIGNED != 0, SAT != 0);
   end

   assign unused_res_hi = ^res_c.sum[MAX_BW-1:ADD_BW];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_b <= '0;
         ovf_b <= 1'b0;
         v_b   <= 1'b0;
      end else begin
         v_b <= v_a;
         if (v_a) begin
            sum_b <= res_c.sum[ADD_BW-1:0];
            ovf_b <= res_c.ovf;
         end
      end
   end

   // ovf_set is taken at the input of the last register so the sticky flag
   // rises on the same edge the offending result lands on bot.
   if (PIPE == 3) begin : g_out_reg
      logic [ADD_BW-1:0] sum_c;
      logic              v_c;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sum_c <= '0;
            v_c   <= 1'b0;
         end else begin
            v_c <= v_b;
            if (v_b) sum_c <= sum_b;
         end
      end
      assign bot       = sum_c;
      assign bot_valid = v_c;
      assign ovf_set   = v_b & ovf_b;
   end else begin : g_no_out_reg
      logic unused_ovf_b;
      assign unused_ovf_b = ovf_b;
      assign bot          = sum_b;
      assign bot_valid    = v_b;
      assign ovf_set      = v_a & res_c.ovf;
   end

endmodule

// File: rtl/pe_dbuf.sv
// Weight-stationary PE with shadow/active weight registers; swap travels right with the data.
module pe_dbuf
   import pe_pkg::*;
#(
   parameter int MUL_BW = 16,
   parameter int ADD_BW = 32,
   parameter int PIPE   = 1,
   parameter int SIGNED = 1,
   parameter int SAT    = 1
) (
   input logic      clk,
   input logic      rst,
   pe_dbuf_if.slave bus
);

   if (!cfg_ok(MUL_BW, ADD_BW, PIPE)) begin : g_cfg_err
      $error("pe_dbuf: illegal MUL_BW/ADD_BW/PIPE combination");
   end

   logic [MUL_BW-1:0] w_shadow, w_active, w_sel;
   logic              ovf_set;

   // A swap applies to the data of its own cycle, hence the bypass from shadow.
   assign w_sel = bus.i_swap ? w_shadow : w_active;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_shadow <= '0;
         w_active <= '0;
      end else begin
         if (bus.i_wload) w_shadow <= bus.i_wtop;
         if (bus.i_swap)  w_active <= w_shadow;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.o_right       <= '0;
         bus.o_right_valid <= 1'b0;
         bus.o_swap        <= 1'b0;
         bus.o_wbot        <= '0;
         bus.o_wload       <= 1'b0;
      end else begin
         bus.o_right       <= bus.i_left;
         bus.o_right_valid <= bus.i_valid;
         bus.o_swap        <= bus.i_swap;
         bus.o_wbot        <= bus.i_wtop;
         bus.o_wload       <= bus.i_wload;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)               bus.o_ovf <= 1'b0;
      else if (ovf_set)      bus.o_ovf <= 1'b1;
      else if (bus.i_clr_ovf) bus.o_ovf <= 1'b0;
   end

   pe_mac_pipe #(
      .MUL_BW (MUL_BW),
      .ADD_BW (ADD_BW),
      .PIPE   (PIPE),
      .SIGNED (SIGNED),
      .SAT    (SAT)
   ) u_mac (
      .clk       (clk),
      .rst       (rst),
      .valid     (bus.i_valid),
      .act       (bus.i_left),
      .wgt       (w_sel),
      .psum      (bus.i_top),
      .bot       (bus.o_bot),
      .bot_valid (bus.o_bot_valid),
      .ovf_set   (ovf_set)
   );

endmodule

// File: tb/tb_pe_dbuf.sv
// Directed bench for pe_dbuf: PIPE=1 signed/wrap/unsigned table, PIPE=2/3 burst, mid-stream reset.
module tb_pe_dbuf;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid, wload, swap, clr;
   logic [15:0] left, wtop;
   logic [31:0] top;

   int errors = 0;
   int checks = 0;
   int cur_row = -1;

   bit [15:0] m_shadow = 16'h0;
   bit [15:0] m_active = 16'h0;

   always #5 clk = ~clk;

   pe_dbuf_if #(.MUL_BW(16), .ADD_BW(32)) bus_s1 ();
   pe_dbuf_if #(.MUL_BW(16), .ADD_BW(32)) bus_w1 ();
   pe_dbuf_if #(.MUL_BW(16), .ADD_BW(32)) bus_u1 ();
   pe_dbuf_if #(.MUL_BW(16), .ADD_BW(32)) bus_p2 ();
   pe_dbuf_if #(.MUL_BW(16), .ADD_BW(32)) bus_p3 ();

   assign bus_s1.i_valid = valid; assign bus_s1.i_left = left; assign bus_s1.i_top = top;
   assign bus_s1.i_swap = swap; assign bus_s1.i_wload = wload; assign bus_s1.i_wtop = wtop;
   assign bus_s1.i_clr_ovf = clr;
   assign bus_w1.i_valid = valid; assign bus_w1.i_left = left; assign bus_w1.i_top = top;
   assign bus_w1.i_swap = swap; assign bus_w1.i_wload = wload; assign bus_w1.i_wtop = wtop;
   assign bus_w1.i_clr_ovf = clr;
   assign bus_u1.i_valid = valid; assign bus_u1.i_left = left; assign bus_u1.i_top = top;
   assign bus_u1.i_swap = swap; assign bus_u1.i_wload = wload; assign bus_u1.i_wtop = wtop;
   assign bus_u1.i_clr_ovf = clr;
   assign bus_p2.i_valid = valid; assign bus_p2.i_left = left; assign bus_p2.i_top = top;
   assign bus_p2.i_swap = swap; assign bus_p2.i_wload = wload; assign bus_p2.i_wtop = wtop;
   assign bus_p2.i_clr_ovf = clr;
   assign bus_p3.i_valid = valid; assign bus_p3.i_left = left; assign bus_p3.i_top = top;
   assign bus_p3.i_swap = swap; assign bus_p3.i_wload = wload; assign bus_p3.i_wtop = wtop;
   assign bus_p3.i_clr_ovf = clr;

   pe_dbuf #(.MUL_BW(16), .ADD_BW(32), .PIPE(1), .SIGNED(1), .SAT(1)) u_s1 (.clk(clk), .rst(rst), .bus(bus_s1));
   pe_dbuf #(.MUL_BW(16), .ADD_BW(32), .PIPE(1), .SIGNED(1), .SAT(0)) u_w1 (.clk(clk), .rst(rst), .bus(bus_w1));
   pe_dbuf #(.MUL_BW(16), .ADD_BW(32), .PIPE(1), .SIGNED(0), .SAT(1)) u_u1 (.clk(clk), .rst(rst), .bus(bus_u1));
   pe_dbuf #(.MUL_BW(16), .ADD_BW(32), .PIPE(2), .SIGNED(1), .SAT(1)) u_p2 (.clk(clk), .rst(rst), .bus(bus_p2));
   pe_dbuf #(.MUL_BW(16), .ADD_BW(32), .PIPE(3), .SIGNED(1), .SAT(1)) u_p3 (.clk(clk), .rst(rst), .bus(bus_p3));

   typedef struct {
      bit [31:0] valid, left, top, wload, wtop, swap, clr;
      bit [31:0] ev, bs, bw, os, bu, ou;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row=%0d got=%h want=%h", nm, cur_row, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one cycle of inputs, tracks the expected weights and returns the weight used.
   task automatic issue(input bit v, input bit [15:0] l, input bit [31:0] t, input bit wl,
                        input bit [15:0] wt, input bit sw, input bit cl, output bit [15:0] ws);
      valid = v; left = l; top = t; wload = wl; wtop = wt; swap = sw; clr = cl;
      ws = sw ? m_shadow : m_active;
      if (sw) m_active = m_shadow;
      if (wl) m_shadow = wt;
      step();
   endtask

   function automatic logic [32:0] ref_mac(input logic [15:0] a, input logic [15:0] w,
                                           input logic [31:0] t, input bit sgn, input bit sat);
      longint s;
      if (sgn) begin
         s = longint'($signed(a)) * longint'($signed(w)) + longint'($signed(t));
         if (s > 64'sd2147483647)       return {1'b1, sat ? 32'h7FFF_FFFF : s[31:0]};
         else if (s < -64'sd2147483648) return {1'b1, sat ? 32'h8000_0000 : s[31:0]};
         else                           return {1'b0, s[31:0]};
      end else begin
         s = longint'({48'h0, a}) * longint'({48'h0, w}) + longint'({32'h0, t});
         if (s > 64'sh0_FFFF_FFFF) return {1'b1, sat ? 32'hFFFF_FFFF : s[31:0]};
         else                      return {1'b0, s[31:0]};
      end
   endfunction

   initial begin
      bit [15:0]   ws, l, wt;
      bit [31:0]   t;
      logic [32:0] r;
      logic [31:0] b_exp[8];

      //            valid left     top          wload wtop    swap clr  ev bs            bw            os bu            ou
      vecs[0]  = '{0, 0,       0,           1, 3,       0, 0, 0, 0,           0,           0, 0,           0};
      vecs[1]  = '{1, 2,       'h10,        0, 0,       1, 0, 1, 'h16,        'h16,        0, 'h16,        0};
      vecs[2]  = '{1, 4,       1,           1, 2,       0, 0, 1, 'hD,         'hD,         0, 'hD,         0};
      vecs[3]  = '{0, 0,       0,           0, 0,       1, 0, 0, 'hD,         'hD,         0, 'hD,         0};
      vecs[4]  = '{1, 1,       0,           1, 5,       0, 0, 1, 2,           2,           0, 2,           0};
      vecs[5]  = '{1, 1,       0,           1, 9,       1, 0, 1, 5,           5,           0, 5,           0};
      vecs[6]  = '{1, 1,       0,           0, 0,       0, 0, 1, 5,           5,           0, 5,           0};
      vecs[7]  = '{1, 1,       0,           0, 0,       1, 0, 1, 9,           9,           0, 9,           0};
      vecs[8]  = '{0, 0,       0,           1, 'hFFFF,  0, 0, 0, 9,           9,           0, 9,           0};
      vecs[9]  = '{1, 'hFFFF,  'hFFFFFFFF,  0, 0,       1, 0, 1, 0,           0,           0, 'hFFFFFFFF,  1};
      vecs[10] = '{1, 'h7FFF,  'h80000000,  0, 0,       0, 0, 1, 'h80000000,  'h7FFF8001,  1, 'hFFFE8001,  1};
      vecs[11] = '{1, 1,       'h7FFFFFFF,  0, 0,       0, 0, 1, 'h7FFFFFFE,  'h7FFFFFFE,  1, 'h8000FFFE,  1};
      vecs[12] = '{0, 0,       0,           0, 0,       0, 1, 0, 'h7FFFFFFE,  'h7FFFFFFE,  0, 'h8000FFFE,  0};
      vecs[13] = '{1, 'h8000,  'h7FFFFFFF,  0, 0,       0, 1, 1, 'h7FFFFFFF,  'h80007FFF,  1, 'hFFFF7FFF,  0};
      vecs[14] = '{0, 0,       0,           0, 0,       0, 1, 0, 'h7FFFFFFF,  'h80007FFF,  0, 'hFFFF7FFF,  0};

      valid = 0; left = 0; top = 0; wload = 0; wtop = 0; swap = 0; clr = 0;
      step(); step();
      rst = 1'b0;
      step();

      chk("rst_bot", bus_s1.o_bot, 32'h0);
      chk("rst_bot_valid", 32'(bus_s1.o_bot_valid), 32'h0);
      chk("rst_right", 32'(bus_s1.o_right), 32'h0);
      chk("rst_right_valid", 32'(bus_s1.o_right_valid), 32'h0);
      chk("rst_wbot", 32'(bus_s1.o_wbot), 32'h0);
      chk("rst_wload", 32'(bus_s1.o_wload), 32'h0);
      chk("rst_swap", 32'(bus_s1.o_swap), 32'h0);
      chk("rst_ovf", 32'(bus_s1.o_ovf), 32'h0);
      chk("rst_p3_bot", bus_p3.o_bot, 32'h0);

      for (int i = 0; i < 15; i++) begin
         cur_row = i;
         issue(vecs[i].valid[0], vecs[i].left[15:0], vecs[i].top, vecs[i].wload[0],
               vecs[i].wtop[15:0], vecs[i].swap[0], vecs[i].clr[0], ws);
         chk("s1_valid", 32'(bus_s1.o_bot_valid), vecs[i].ev);
         chk("s1_bot", bus_s1.o_bot, vecs[i].bs);
         chk("s1_ovf", 32'(bus_s1.o_ovf), vecs[i].os);
         chk("w1_bot", bus_w1.o_bot, vecs[i].bw);
         chk("w1_ovf", 32'(bus_w1.o_ovf), vecs[i].os);
         chk("u1_bot", bus_u1.o_bot, vecs[i].bu);
         chk("u1_ovf", 32'(bus_u1.o_ovf), vecs[i].ou);
         chk("right", 32'(bus_s1.o_right), vecs[i].left);
         chk("right_valid", 32'(bus_s1.o_right_valid), vecs[i].valid);
         chk("wbot", 32'(bus_s1.o_wbot), vecs[i].wtop);
         chk("wload", 32'(bus_s1.o_wload), vecs[i].wload);
         chk("swap", 32'(bus_s1.o_swap), vecs[i].swap);
      end

      // Back-to-back burst with a load at k=2 and a swap at k=5; PIPE=2 and PIPE=3 outputs.
      for (int k = 0; k <= 10; k++) begin
         cur_row = 100 + k;
         if (k < 8) begin
            l  = 16'($urandom);
            t  = $urandom;
            wt = 16'($urandom);
            issue(1'b1, l, t, k == 2, wt, k == 5, 1'b0, ws);
            r = ref_mac(l, ws, t, 1'b1, 1'b1);
            b_exp[k] = r[31:0];
         end else begin
            issue(1'b0, 16'h0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b0, ws);
         end
         if (k >= 1 && k <= 8) begin
            chk("p2_valid", 32'(bus_p2.o_bot_valid), 32'h1);
            chk("p2_bot", bus_p2.o_bot, b_exp[k-1]);
         end else if (k > 8) begin
            chk("p2_valid_idle", 32'(bus_p2.o_bot_valid), 32'h0);
         end
         if (k >= 2 && k <= 9) begin
            chk("p3_valid", 32'(bus_p3.o_bot_valid), 32'h1);
            chk("p3_bot", bus_p3.o_bot, b_exp[k-2]);
         end else if (k == 10) begin
            chk("p3_valid_idle", 32'(bus_p3.o_bot_valid), 32'h0);
         end
      end

      // Mid-stream reset with two results in flight in the PIPE=3 cell.
      cur_row = 200;
      issue(1'b1, 16'h1, 32'h7, 1'b0, 16'h0, 1'b0, 1'b0, ws);
      issue(1'b1, 16'h2, 32'h7, 1'b1, 16'h1234, 1'b1, 1'b0, ws);
      valid = 0; left = 0; top = 0; wload = 0; wtop = 0; swap = 0; clr = 0;
      #2 rst = 1'b1;
      #1;
      chk("mrst_p3_bot", bus_p3.o_bot, 32'h0);
      chk("mrst_p3_bot_valid", 32'(bus_p3.o_bot_valid), 32'h0);
      chk("mrst_p3_right", 32'(bus_p3.o_right), 32'h0);
      chk("mrst_p3_right_valid", 32'(bus_p3.o_right_valid), 32'h0);
      chk("mrst_p3_wbot", 32'(bus_p3.o_wbot), 32'h0);
      chk("mrst_p3_wload", 32'(bus_p3.o_wload), 32'h0);
      chk("mrst_p3_swap", 32'(bus_p3.o_swap), 32'h0);
      chk("mrst_p3_ovf", 32'(bus_p3.o_ovf), 32'h0);
      chk("mrst_s1_ovf", 32'(bus_s1.o_ovf), 32'h0);
      step(); step();
      rst = 1'b0;
      m_shadow = 16'h0;
      m_active = 16'h0;
      for (int k = 0; k < 4; k++) begin
         cur_row = 210 + k;
         step();
         chk("post_rst_p3_valid", 32'(bus_p3.o_bot_valid), 32'h0);
         chk("post_rst_p3_bot", bus_p3.o_bot, 32'h0);
      end

      // Both weights were cleared: a swap and a plain cycle both multiply by zero.
      cur_row = 220;
      issue(1'b1, 16'h1, 32'h5, 1'b0, 16'h0, 1'b1, 1'b0, ws);
      chk("post_rst_shadow_zero", bus_s1.o_bot, 32'h5);
      cur_row = 221;
      issue(1'b1, 16'h1, 32'h5, 1'b0, 16'h0, 1'b0, 1'b0, ws);
      chk("post_rst_active_zero", bus_s1.o_bot, 32'h5);
      issue(1'b0, 16'h0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b0, ws);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pe_dbuf.md
# pe_dbuf

Parametrised weight-stationary processing element for the systolic array, with double-buffered weights. Weights stream down a dedicated chain into a shadow register while the active weight keeps computing. The swap to the new weight travels right with the data wavefront. The MAC path has configurable pipeline depth, signed or unsigned arithmetic, and optional saturation with a sticky overflow flag. One instance per array cell; it supersedes the single-buffer PE.

## Interface
- MUL_BW, 16: width of activation and weight operands.
- ADD_BW, 32: partial-sum width; must be ≥ 2*MUL_BW.
- PIPE, 1: MAC pipeline depth, legal values 1..3.
- SIGNED, 1: 1 means two's-complement operands; 0 means unsigned.
- SAT, 1: 1 means saturating accumulate; 0 means wrap-around.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  i_left and i_top are valid this cycle.
- i_left  in  MUL_BW  activation from the left neighbour.
- i_top  in  ADD_BW  partial sum from above.
- i_swap  in  1  promote the shadow weight to active, aligned with this cycle's data.
- i_wload  in  1  i_wtop is valid; capture it into the shadow register.
- i_wtop  in  MUL_BW  weight chain input from above.
- i_clr_ovf  in  1  clear the sticky overflow flag.
- o_right  out  MUL_BW  registered i_left.
- o_right_valid  out  1  registered i_valid.
- o_swap  out  1  registered i_swap.
- o_bot  out  ADD_BW  MAC result.
- o_bot_valid  out  1  o_bot is valid.
- o_wbot  out  MUL_BW  registered i_wtop.
- o_wload  out  1  registered i_wload.
- o_ovf  out  1  sticky saturation/overflow flag.

## Operation
- Two weight registers:
  - w_shadow: on i_wload, w_shadow <= i_wtop.
  - w_active: on i_swap, w_active <= w_shadow.
- Weight used for this cycle's data: w_sel = i_swap ? w_shadow : w_active. The swap therefore applies to data in the same cycle.
- i_wload and i_swap in the same cycle: the swap promotes the pre-load shadow value, and the shadow takes the new i_wtop.
- Weight loading is independent of compute. Loads never stall or corrupt in-flight results.
- Product:
  - i_left * w_sel, 2*MUL_BW wide.
  - Extended to ADD_BW: sign-extended if SIGNED=1, zero-extended otherwise.
  - Added to i_top at ADD_BW+1 bits.
- Overflow when SIGNED=1: the signed result falls outside the ADD_BW signed range.
- Overflow when SIGNED=0: the carry out is set.
- On overflow with SAT=1:
  - o_bot clamps to the signed max/min, or to all-ones in unsigned mode.
  - o_ovf sets.
- On overflow with SAT=0: o_bot wraps and o_ovf still sets.
- o_ovf clears only on rst or i_clr_ovf. If an overflow and i_clr_ovf occur in the same cycle, the set wins.
- When i_valid=0, no MAC is issued and o_bot_valid stays 0 for that slot. o_bot holds its previous value.

## Timing
- Reset value of every output and every internal register is 0, including both weights.
- Reset mid-operation discards all in-flight results. o_bot_valid is 0 from the first cycle after rst deasserts.
- o_right, o_right_valid, o_swap, o_wbot and o_wload: latency 1.
- o_bot and o_bot_valid: latency PIPE cycles after the i_valid cycle.
  - PIPE=1: a single registered multiply-add.
  - PIPE=2: the product and i_top are registered, then the add/saturate is registered.
  - PIPE=3: as PIPE=2, plus an output register.
- Full throughput: one MAC per cycle with back-to-back i_valid.
- Each result uses the weight selected in its issue cycle, regardless of later swaps.
- o_ovf updates in the same cycle that the overflowing result appears on o_bot.

## Structure
- Package pe_pkg holds:
  - the PIPE_MIN=1 and PIPE_MAX=3 constants;
  - the sat_add function, parametrised by signedness;
  - the elaboration-time check ADD_BW ≥ 2*MUL_BW.
- Sub-module pe_mac_pipe: the multiply, extend, add and saturate datapath with PIPE stages and a valid shift register.
- Top level pe_dbuf holds the weight registers, the pass-through registers and o_ovf.

## Test plan
- Reset: assert rst mid-stream with PIPE=3 and two results in flight. All outputs read 0 and no o_bot_valid pulse appears after release.
- Load and swap, SIGNED=1, PIPE=1:
  - Stimulus: i_wload with i_wtop=0x0003, then i_swap with i_valid, i_left=0x0002, i_top=0x00000010.
  - Response: o_bot=0x00000016 one cycle later; o_wbot=0x0003 and o_wload=1 one cycle after the load.
- Simultaneous load and swap:
  - Setup: shadow=5, active=2.
  - Stimulus: i_wload with i_wtop=9, i_swap, and i_valid with i_left=1, i_top=0.
  - Response: o_bot=5, active=5, shadow=9.
- Signed edge, SIGNED=1:
  - Stimulus: weight 0xFFFF, i_left=0xFFFF, i_top=0xFFFFFFFF.
  - Response: o_bot=0x00000000 and o_ovf=0.
- Unsigned saturation, SIGNED=0, SAT=1:
  - Stimulus: same operands as the signed edge.
  - Response: o_bot=0xFFFFFFFF and o_ovf=1, held until i_clr_ovf.
- Pipelining, PIPE=2:
  - Stimulus: 8 back-to-back random valid samples with i_swap mid-burst.
  - Response: each o_bot matches the reference model 2 cycles later, using the weight selected at issue.
